// File: rtl/tqv_bus_master.sv
// tqv_bus_master: turns single command/response transactions into
// strobe-based peripheral bus accesses, with a bounded wait for the
// peripheral and an error response for illegal access sizes.
module tqv_bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic [5:0]  address,
  output logic [31:0] data_in,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_out,
  input  logic        data_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] STROBE_IDLE = 2'b11;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;
  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_SIZE = 2'b10;
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  logic        reg_write;
  logic [1:0]  reg_size;
  logic [7:0]  wait_cnt;

  // Keeps only the bytes belonging to the access size; reads are zero-extended.
  function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'b00:   r = {24'd0, d[7:0]};
      2'b01:   r = {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Single FSM; every output is a register so reset clears the bus strobes at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      reg_write    <= 1'b0;
      reg_size     <= 2'b00;
      wait_cnt     <= 8'd0;
      address      <= 6'd0;
      data_in      <= 32'd0;
      data_write_n <= STROBE_IDLE;
      data_read_n  <= STROBE_IDLE;
      rsp_valid    <= 1'b0;
      rsp_data     <= 32'd0;
      rsp_err      <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_size == SIZE_ILLEGAL) begin
              state <= ERR;
            end else begin
              state        <= BUS;
              reg_write    <= cmd_write;
              reg_size     <= cmd_size;
              wait_cnt     <= 8'd0;
              address      <= cmd_addr;
              data_in      <= cmd_wdata;
              data_write_n <= cmd_write ? cmd_size : STROBE_IDLE;
              data_read_n  <= cmd_write ? STROBE_IDLE : cmd_size;
            end
          end
        end

        BUS: begin
          if (data_ready || (wait_cnt == LAST_WAIT)) begin
            state        <= RESP;
            rsp_valid    <= 1'b1;
            address      <= 6'd0;
            data_in      <= 32'd0;
            data_write_n <= STROBE_IDLE;
            data_read_n  <= STROBE_IDLE;
            if (data_ready) begin
              rsp_err  <= ERR_OK;
              rsp_data <= reg_write ? 32'd0 : size_mask(reg_size, data_out);
            end else begin
              rsp_err  <= ERR_TIMEOUT;
              rsp_data <= 32'd0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ERR: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= ERR_SIZE;
          rsp_data  <= 32'd0;
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_err   <= ERR_OK;
            wait_cnt  <= 8'd0;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tqv_bus_master.sv
// tb_tqv_bus_master: directed vector table, randomized transactions against a
// transaction-level outcome model, plus hand sequences for backpressure,
// back-to-back commands and reset in the middle of a bus access.
module tb_tqv_bus_master;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  int n_checks = 0;
  int n_fail = 0;

  tqv_bus_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [5:0]  ad;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    int          rdly;
    logic [1:0]  e_err;
    logic [31:0] e_data;
    int          e_strb;
    string       tag;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Outcome of one transaction from the rules: illegal size -> error, the
  // peripheral answering within TO bus cycles -> ok, otherwise timeout.
  task automatic model(input logic w, input logic [1:0] sz, input logic [31:0] rd, input int dly,
                       output logic [1:0] e_err, output logic [31:0] e_data, output int e_strb);
    logic [63:0] m;
    if (sz == 2'b11) begin
      e_err = 2'b10; e_data = 32'd0; e_strb = 0;
    end else if (dly < TO) begin
      m = (64'd1 << (8 << sz)) - 64'd1;
      e_err = 2'b00; e_strb = dly + 1;
      e_data = w ? 32'd0 : (rd & m[31:0]);
    end else begin
      e_err = 2'b01; e_data = 32'd0; e_strb = TO;
    end
  endtask

  // Runs one command from acceptance to consumption; entered and left just after a negedge.
  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic [5:0] ad,
                               input logic [31:0] wd, input logic [31:0] rd, input int dly,
                               input int rdly, input logic [1:0] e_err, input logic [31:0] e_data,
                               input int e_strb, input string tag);
    int strb;
    int errc;
    bit got;
    strb = 0; errc = 0; got = 0;
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_size = sz; cmd_addr = ad; cmd_wdata = wd;
    data_out = rd; data_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = ~wd;
    cmd_addr = ~ad;
    for (int c = 0; c < 40 && !got; c++) begin
      if (rsp_valid) begin
        got = 1;
      end else if (data_write_n != 2'b11 || data_read_n != 2'b11) begin
        checkOutput({tag, "_write_n"}, 32'(data_write_n), 32'(w ? sz : 2'b11));
        checkOutput({tag, "_read_n"}, 32'(data_read_n), 32'(w ? 2'b11 : sz));
        checkOutput({tag, "_address"}, 32'(address), 32'(ad));
        checkOutput({tag, "_data_in"}, data_in, wd);
        data_ready = (strb == dly);
        strb++;
      end else begin
        errc++;
        data_ready = 1'b1;
        checkOutput({tag, "_addr_err"}, 32'(address), 32'd0);
      end
      if (!got) @(negedge clk);
    end
    data_ready = 1'b0;
    checkOutput({tag, "_rsp_seen"}, 32'(got), 32'd1);
    if (!got) return;
    checkOutput({tag, "_strobe_cycles"}, 32'(strb), 32'(e_strb));
    checkOutput({tag, "_err_cycles"}, 32'(errc), (sz == 2'b11) ? 32'd1 : 32'd0);
    checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'(e_err));
    checkOutput({tag, "_rsp_data"}, rsp_data, e_data);
    checkOutput({tag, "_resp_strobes"}, 32'({data_write_n, data_read_n}), 32'hF);
    checkOutput({tag, "_resp_bus"}, data_in | 32'(address), 32'd0);
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, "_hold_data"}, rsp_data, e_data);
      checkOutput({tag, "_hold_err"}, 32'(rsp_err), 32'(e_err));
      checkOutput({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, "_consumed_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_consumed_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [1:0]  r_err;
    logic [31:0] r_data;
    int          r_strb;
    logic        w;
    logic [1:0]  sz;
    logic [31:0] rd;
    int          dly;

    vecs[0] = '{1'b1, 2'b10, 6'h00, 32'h0000_4000, 32'h1234_5678, 3, 0, 2'b00, 32'h0, 4, "wr32_dly3"};
    vecs[1] = '{1'b0, 2'b00, 6'h05, 32'h0, 32'hDEAD_BEEF, 0, 1, 2'b00, 32'h0000_00EF, 1, "rd8"};
    vecs[2] = '{1'b0, 2'b01, 6'h2A, 32'h0, 32'h5555_AAAA, 99, 0, 2'b01, 32'h0, 4, "rd16_timeout"};
    vecs[3] = '{1'b1, 2'b11, 6'h3F, 32'hFFFF_FFFF, 32'h0, 0, 2, 2'b10, 32'h0, 0, "illegal_wr"};
    vecs[4] = '{1'b0, 2'b01, 6'h10, 32'h0, 32'hCAFE_F00D, 1, 0, 2'b00, 32'h0000_F00D, 2, "rd16"};
    vecs[5] = '{1'b0, 2'b10, 6'h21, 32'h0, 32'h8000_0001, 2, 0, 2'b00, 32'h8000_0001, 3, "rd32"};
    vecs[6] = '{1'b1, 2'b00, 6'h11, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 0, 2'b00, 32'h0, 1, "wr8"};
    vecs[7] = '{1'b0, 2'b11, 6'h01, 32'h0, 32'hFFFF_FFFF, 0, 0, 2'b10, 32'h0, 0, "illegal_rd"};
    vecs[8] = '{1'b0, 2'b10, 6'h02, 32'h0, 32'h1111_2222, 4, 0, 2'b01, 32'h0, 4, "rd32_timeout"};

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00; cmd_addr = 6'd0;
    cmd_wdata = 32'd0; data_out = 32'd0; data_ready = 1'b0; rsp_ready = 1'b0;
    #3;
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_strobes", 32'({data_write_n, data_read_n}), 32'hF);
    checkOutput("reset_bus", data_in | 32'(address), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp", rsp_data | 32'(rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      applyStimulus(vecs[i].w, vecs[i].sz, vecs[i].ad, vecs[i].wd, vecs[i].rd, vecs[i].dly,
                    vecs[i].rdly, vecs[i].e_err, vecs[i].e_data, vecs[i].e_strb, vecs[i].tag);

    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      rd = $urandom;
      dly = $urandom_range(0, 6);
      model(w, sz, rd, dly, r_err, r_data, r_strb);
      applyStimulus(w, sz, 6'($urandom), $urandom, rd, dly, $urandom_range(0, 3),
                    r_err, r_data, r_strb, $sformatf("rand%0d", i));
    end

    // Backpressure with a second command waiting behind the first.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b00; cmd_addr = 6'h05;
    cmd_wdata = 32'd0; data_out = 32'h1122_3344; data_ready = 1'b0;
    @(negedge clk);
    checkOutput("b2b_first_strobe", 32'(data_read_n), 32'd0);
    checkOutput("b2b_first_addr", 32'(address), 32'h05);
    cmd_write = 1'b1; cmd_size = 2'b01; cmd_addr = 6'h09; cmd_wdata = 32'h0000_BEEF;
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    checkOutput("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("b2b_rsp_data", rsp_data, 32'h0000_0044);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("b2b_hold_data", rsp_data, 32'h0000_0044);
      checkOutput("b2b_hold_err", 32'(rsp_err), 32'd0);
      checkOutput("b2b_hold_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("b2b_hold_no_write", 32'(data_write_n), 32'd3);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("b2b_consumed_valid", 32'(rsp_valid), 32'd0);
    checkOutput("b2b_consumed_ready", 32'(cmd_ready), 32'd1);
    checkOutput("b2b_not_yet_accepted", 32'(data_write_n), 32'd3);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("b2b_second_strobe", 32'(data_write_n), 32'd1);
    checkOutput("b2b_second_addr", 32'(address), 32'h09);
    checkOutput("b2b_second_data", data_in, 32'h0000_BEEF);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    checkOutput("b2b_second_rsp", 32'(rsp_valid), 32'd1);
    checkOutput("b2b_second_data_zero", rsp_data, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset in the middle of a read; strobes must drop before any clock edge.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b10; cmd_addr = 6'h07;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("rst_bus_strobe", 32'(data_read_n), 32'd2);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async_strobes", 32'({data_write_n, data_read_n}), 32'hF);
    checkOutput("rst_async_addr", 32'(address), 32'd0);
    checkOutput("rst_async_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("rst_no_rsp", 32'(rsp_valid), 32'd0);
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    data_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tqv_bus_master.md
TQV_BUS_MASTER -- requirements
Module: tqv_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of bus-wait cycles before an access is aborted (legal range 1..255).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 cmd_valid  input  1  SHALL indicate a pending command.
REQ-005 cmd_ready  output  1  SHALL indicate the block accepts a command this cycle.
REQ-006 cmd_write  input  1  SHALL select write (1) or read (0).
REQ-007 cmd_size  input  2  SHALL encode access size: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal.
REQ-008 cmd_addr  input  6  SHALL carry the peripheral register address.
REQ-009 cmd_wdata  input  32  SHALL carry the write data.
REQ-010 address  output  6  SHALL drive the peripheral address.
REQ-011 data_in  output  32  SHALL drive the peripheral write data.
REQ-012 data_write_n  output  2  SHALL drive the write strobe: 11 = idle, otherwise the size code.
REQ-013 data_read_n  output  2  SHALL drive the read strobe: 11 = idle, otherwise the size code.
REQ-014 data_out  input  32  SHALL carry the peripheral read data.
REQ-015 data_ready  input  1  SHALL signal peripheral completion.
REQ-016 rsp_valid  output  1  SHALL indicate a response is held.
REQ-017 rsp_ready  input  1  SHALL indicate the consumer takes the response.
REQ-018 rsp_data  output  32  SHALL carry the read data, zero-extended; 0 for writes and errors.
REQ-019 rsp_err  output  2  SHALL carry the status: 00 = ok, 01 = timeout, 10 = illegal size.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, BUS, RESP, ERR.
REQ-021 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle where cmd_valid & cmd_ready.
REQ-022 On acceptance with cmd_size != 11, the FSM SHALL register cmd_write, cmd_size, cmd_addr and cmd_wdata and go to BUS.
REQ-023 On acceptance with cmd_size == 11, the FSM SHALL go to ERR, with no bus strobe ever asserted.
REQ-024 In BUS, the strobe selected by cmd_write SHALL equal the registered size code; the other strobe SHALL be 11.
REQ-025 In BUS, address and data_in SHALL hold the registered values and stay stable for the whole state.
REQ-026 Outside BUS, both strobes SHALL be 11, address SHALL be 0 and data_in SHALL be 0.
REQ-027 In BUS, a wait counter SHALL start at 0 on entry and increment each cycle that data_ready is 0.
REQ-028 data_ready = 1 sampled in BUS SHALL move the FSM to RESP with rsp_err = 00.
REQ-029 On that same transition, a read SHALL capture data_out masked to its size: 8-bit keeps [7:0], 16-bit keeps [15:0], 32-bit keeps all bits.
REQ-030 When the counter equals TIMEOUT-1 and data_ready is 0, the FSM SHALL move to RESP with rsp_err = 01 and rsp_data = 0.
REQ-031 If data_ready and the timeout condition coincide, data_ready SHALL win (ok response).
REQ-032 The minimum latency SHALL be: command accepted at cycle N, strobe asserted at N+1, rsp_valid at N+2 (when data_ready is 1 at N+1).
REQ-033 ERR SHALL last one cycle and then move to RESP with rsp_err = 10 and rsp_data = 0.
REQ-034 In RESP, rsp_valid SHALL be 1 and rsp_data and rsp_err SHALL be stable until rsp_valid & rsp_ready; the FSM then returns to IDLE.
REQ-035 A command SHALL NOT be accepted in the cycle the response is consumed.
REQ-036 data_ready SHALL be ignored outside BUS.
REQ-037 rsp_valid SHALL be 0 outside RESP.

Reset
REQ-038 While reset is asserted, the FSM SHALL be forced to IDLE and all outputs to their reset values, independent of clk.
REQ-039 Reset values: cmd_ready = 1, both strobes 11, address 0, data_in 0, rsp_valid 0, rsp_data 0, rsp_err 00, counter 0.
REQ-040 Reset asserted during BUS SHALL return both strobes to 11 immediately, and the in-flight access SHALL be discarded with no response.

Verification
REQ-041 32-bit write: addr 0x00, data 0x0000_4000, with data_ready asserted 3 cycles after the strobe -> data_write_n = 10 for 4 cycles, then rsp_valid with rsp_err 00 and rsp_data 0.
REQ-042 8-bit read: addr 0x05, with data_out = 0xDEAD_BEEF and data_ready asserted the first BUS cycle -> rsp_data = 0x0000_00EF at N+2.
REQ-043 16-bit read with TIMEOUT = 4 and data_ready never asserted -> data_read_n = 01 for exactly 4 cycles, then rsp_err 01 and rsp_data 0.
REQ-044 Command with cmd_size = 11 -> strobes remain 11 throughout, and rsp_err = 10 two cycles after acceptance.
REQ-045 rsp_ready held 0 for 5 cycles -> rsp_data and rsp_err stable, cmd_ready = 0; with back-to-back cmd_valid, the second command is accepted only the cycle after consumption.
REQ-046 Reset pulsed mid-BUS -> strobes 11 without waiting for a clk edge, rsp_valid never asserted, and cmd_ready = 1 after release.
